receiver_pwm_decoder: RTL



---
 rtl/receiver_pwm_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/receiver_pwm_decoder.sv
`timescale 1ns/1ps
// receiver_pwm_decoder
//   Decodes one RC-receiver PWM channel (1000-2000 us high pulse, ~50 Hz)
//   into an 8-bit command for the throttle change limiter.
//   Pulses outside the glitch window are measured but dropped.
//   When no accepted pulse arrives for TIMEOUT_US, the command is forced to
//   zero (fail-safe).
//
// Ports
//   us_clk          in   1    1 MHz clock, one cycle per microsecond
//   reset           in   1    asynchronous, active-high reset
//   pwm_in          in   1    raw receiver pulse, asynchronous to us_clk
//   value_out       out  8    decoded command 0..250, held between updates
//   valid_strobe    out  1    one-cycle pulse on every value_out update
//   signal_lost     out  1    high while in fail-safe
//   pulse_width_us  out  12   last measured width, accepted or not
module receiver_pwm_decoder #(
    parameter int REC_VAL_BIT_WIDTH = 8,
    parameter int MIN_US            = 1000,
    parameter int MAX_US            = 2000,
    parameter int SHIFT             = 2,
    parameter int GLITCH_MIN_US     = 800,
    parameter int GLITCH_MAX_US     = 2200,
    parameter int TIMEOUT_US        = 50000
) (
    input  logic                         us_clk,
    input  logic                         reset,
    input  logic                         pwm_in,
    output logic [REC_VAL_BIT_WIDTH-1:0] value_out,
    output logic                         valid_strobe,
    output logic                         signal_lost,
    output logic [11:0]                  pulse_width_us
);

    localparam logic [11:0] MIN_W        = 12'(MIN_US);
    localparam logic [11:0] MAX_W        = 12'(MAX_US);
    localparam logic [11:0] GLITCH_MIN_W = 12'(GLITCH_MIN_US);
    localparam logic [11:0] GLITCH_MAX_W = 12'(GLITCH_MAX_US);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_US);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        CHECK     = 2'd3
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic [11:0] width_cnt;
    logic [15:0] timeout_cnt;
    logic        rise, fall;
    logic        in_window;
    logic        accept;

    // Clamp to [MIN_US, MAX_US], remove offset, scale down; truncating.
    function automatic logic [REC_VAL_BIT_WIDTH-1:0] map_width(input logic [11:0] w);
        logic [11:0] c;
        if (w < MIN_W)
            c = MIN_W;
        else if (w > MAX_W)
            c = MAX_W;
        else
            c = w;
        return REC_VAL_BIT_WIDTH'((c - MIN_W) >> SHIFT);
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign in_window = (width_cnt >= GLITCH_MIN_W) && (width_cnt <= GLITCH_MAX_W);
    assign accept    = (state == CHECK) && in_window;

    // The synchronizer resets to "line high" so that a pulse still in
    // progress when reset is released is not mistaken for a fresh rising
    // edge; ARM then waits for the line to go low before arming.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            s1             <= 1'b1;
            s2             <= 1'b1;
            s3             <= 1'b1;
            state          <= ARM;
            width_cnt      <= 12'd0;
            timeout_cnt    <= 16'd0;
            value_out      <= '0;
            valid_strobe   <= 1'b0;
            signal_lost    <= 1'b1;
            pulse_width_us <= 12'd0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;

            valid_strobe <= 1'b0;

            if (accept)
                timeout_cnt <= 16'd0;
            else
                timeout_cnt <= sat_inc16(timeout_cnt);

            case (state)
                ARM: begin
                    if (!s2)
                        state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        width_cnt <= 12'd1;
                        state     <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall)
                        state <= CHECK;
                    else if (s2)
                        width_cnt <= sat_inc12(width_cnt);
                end
                CHECK: begin
                    pulse_width_us <= width_cnt;
                    state          <= WAIT_RISE;
                    if (in_window) begin
                        value_out    <= map_width(width_cnt);
                        valid_strobe <= 1'b1;
                        signal_lost  <= 1'b0;
                    end
                end
                default: state <= ARM;
            endcase

            // Fail-safe fires once; an accept in the same cycle takes priority.
            if (!accept && !signal_lost && (timeout_cnt >= TIMEOUT_W)) begin
                value_out    <= '0;
                signal_lost  <= 1'b1;
                valid_strobe <= 1'b1;
            end
        end
    end

endmodule
